// File: rtl/bus_arbiter.sv
// Two-master, seven-slave memory bus arbiter with address decode and watchdog.
// Handshake: a master raises m_valid[i] with addr/wdata/wstrb stable and holds
// them until it sees a one-cycle m_ready[i] pulse (m_error qualifies it; m_rdata
// is valid in that cycle). The arbiter raises one s_valid bit, holds it with
// s_addr/s_wdata/s_wstrb stable, and the selected slave ends the request with a
// one-cycle s_ready pulse. No further request is taken in the completion cycle.
module bus_arbiter #(
    parameter logic [6:0][31:0] BASE_ADDR = {32'h80000000, 32'h10000000, 32'h02000000,
                                             32'h01000004, 32'h01000000, 32'h00100000,
                                             32'h00000000},
    parameter logic [6:0][31:0] MASK_ADDR = {32'h000FFFFF, 32'h000FFFFF, 32'h0000FFFF,
                                             32'h00000003, 32'h00000003, 32'h000FFFFF,
                                             32'h000000FF},
    parameter int unsigned      TIMEOUT   = 1024
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       m_valid,
    input  logic [1:0][31:0] m_addr,
    input  logic [1:0][31:0] m_wdata,
    input  logic [1:0][3:0]  m_wstrb,
    output logic [1:0]       m_ready,
    output logic             m_error,
    output logic [31:0]      m_rdata,
    output logic [6:0]       s_valid,
    output logic [31:0]      s_addr,
    output logic [31:0]      s_wdata,
    output logic [3:0]       s_wstrb,
    input  logic [6:0]       s_ready,
    input  logic [6:0][31:0] s_rdata,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    // Watchdog is at least one bit wide even when disabled.
    localparam int unsigned WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

    state_t          state_q, state_d;
    logic            gnt_q, gnt_d;       // master owning the current transaction
    logic            last_q, last_d;     // master granted most recently
    logic [2:0]      sel_q, sel_d;       // decoded slave index
    logic [6:0]      s_valid_q, s_valid_d;
    logic [31:0]     s_addr_q, s_addr_d;
    logic [31:0]     s_wdata_q, s_wdata_d;
    logic [3:0]      s_wstrb_q, s_wstrb_d;
    logic [WD_W-1:0] wd_q, wd_d;

    logic            arb_gnt;
    logic [31:0]     arb_addr;
    logic            hit_any;
    logic [2:0]      hit_idx;
    logic            slave_done;
    logic            wd_expired;

    // Round-robin pick and address decode; lowest matching slave index wins.
    always_comb begin
        arb_gnt = 1'b0;
        case (m_valid)
            2'b10:   arb_gnt = 1'b1;
            2'b11:   arb_gnt = ~last_q;
            default: arb_gnt = 1'b0;
        endcase
        arb_addr = m_addr[arb_gnt];
        hit_any  = 1'b0;
        hit_idx  = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if ((arb_addr & ~MASK_ADDR[i]) == BASE_ADDR[i]) begin
                hit_any = 1'b1;
                hit_idx = 3'(i);
            end
        end
    end

    assign slave_done = s_ready[sel_q];
    assign wd_expired = (TIMEOUT != 0) && (wd_q == WD_LAST);

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            gnt_q     <= 1'b0;
            last_q    <= 1'b0;
            sel_q     <= 3'd0;
            s_valid_q <= 7'd0;
            s_addr_q  <= 32'd0;
            s_wdata_q <= 32'd0;
            s_wstrb_q <= 4'd0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            sel_q     <= sel_d;
            s_valid_q <= s_valid_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            s_wstrb_q <= s_wstrb_d;
            wd_q      <= wd_d;
        end
    end

    // Next-state logic: grant and latch in IDLE, wait/timeout in BUSY.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        sel_d     = sel_q;
        s_valid_d = s_valid_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        s_wstrb_d = s_wstrb_q;
        wd_d      = '0;
        case (state_q)
            ST_IDLE: begin
                if (m_valid != 2'b00) begin
                    gnt_d     = arb_gnt;
                    last_d    = arb_gnt;
                    sel_d     = hit_idx;
                    s_addr_d  = arb_addr;
                    s_wdata_d = m_wdata[arb_gnt];
                    s_wstrb_d = m_wstrb[arb_gnt];
                    if (hit_any) begin
                        state_d   = ST_BUSY;
                        s_valid_d = 7'b1 << hit_idx;
                    end else begin
                        state_d   = ST_ERR;
                        s_valid_d = 7'd0;
                    end
                end
            end
            ST_BUSY: begin
                if (slave_done) begin
                    state_d   = ST_IDLE;
                    s_valid_d = 7'd0;
                end else if (wd_expired) begin
                    state_d   = ST_ERR;
                    s_valid_d = 7'd0;
                end else if (TIMEOUT != 0) begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                s_valid_d = 7'd0;
            end
        endcase
    end

    // Master-side response: combinational completion from BUSY, error from ERR.
    always_comb begin
        m_ready = 2'b00;
        m_error = 1'b0;
        m_rdata = 32'd0;
        case (state_q)
            ST_BUSY: begin
                if (slave_done) begin
                    m_ready[gnt_q] = 1'b1;
                    m_rdata        = s_rdata[sel_q];
                end
            end
            ST_ERR: begin
                m_ready[gnt_q] = 1'b1;
                m_error        = 1'b1;
            end
            default: ;
        endcase
    end

    assign s_valid   = s_valid_q;
    assign s_addr    = s_addr_q;
    assign s_wdata   = s_wdata_q;
    assign s_wstrb   = s_wstrb_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter built with an 8-cycle watchdog.
module tb_bus_arbiter;

    logic             clock;
    logic             reset;
    logic [1:0]       m_valid;
    logic [1:0][31:0] m_addr;
    logic [1:0][31:0] m_wdata;
    logic [1:0][3:0]  m_wstrb;
    logic [1:0]       m_ready;
    logic             m_error;
    logic [31:0]      m_rdata;
    logic [6:0]       s_valid;
    logic [31:0]      s_addr;
    logic [31:0]      s_wdata;
    logic [3:0]       s_wstrb;
    logic [6:0]       s_ready;
    logic [6:0][31:0] s_rdata;
    logic [1:0]       dbg_state;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    bus_arbiter #(.TIMEOUT(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .m_valid   (m_valid),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_ready   (m_ready),
        .m_error   (m_error),
        .m_rdata   (m_rdata),
        .s_valid   (s_valid),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_ready   (s_ready),
        .s_rdata   (s_rdata),
        .dbg_state (dbg_state)
    );

    // Clock and run-time bound.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL run_time_bound observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miss_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered just after the edge that made the arbiter BUSY on slave sl.
    task automatic serve(input int sl, input int waits, input logic [31:0] data,
                         input logic [1:0] exp_mr, input string tag);
        logic [6:0] onehot;
        onehot = 7'b1 << sl;
        for (int k = 0; k < waits; k++) begin
            chk({tag, "_wait_sv"}, 32'(s_valid), 32'(onehot));
            chk({tag, "_wait_mr"}, 32'(m_ready), 32'd0);
            cyc();
        end
        s_ready[sl] = 1'b1;
        s_rdata[sl] = data;
        #1;
        chk({tag, "_done_sv"}, 32'(s_valid), 32'(onehot));
        chk({tag, "_done_mr"}, 32'(m_ready), 32'(exp_mr));
        chk({tag, "_done_err"}, 32'(m_error), 32'd0);
        chk({tag, "_done_rdata"}, m_rdata, data);
        cyc();
        s_ready = 7'd0;
        chk({tag, "_after_sv"}, 32'(s_valid), 32'd0);
        chk({tag, "_after_mr"}, 32'(m_ready), 32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        m_valid = 2'b00;
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        s_ready = 7'd0;
        s_rdata = '0;
        repeat (2) cyc();

        // Reset state.
        chk("rst_state", 32'(dbg_state), 32'd0);
        chk("rst_sv", 32'(s_valid), 32'd0);
        chk("rst_saddr", s_addr, 32'd0);
        chk("rst_mr", 32'(m_ready), 32'd0);
        chk("rst_merr", 32'(m_error), 32'd0);
        chk("rst_rdata", m_rdata, 32'd0);

        // Contention from reset: m1 first, then m0, then m1 again.
        reset     = 1'b0;
        m_valid   = 2'b11;
        m_addr[0] = 32'h00000010;
        m_addr[1] = 32'h80000020;
        cyc();
        chk("rr1_state", 32'(dbg_state), 32'd1);
        chk("rr1_saddr", s_addr, 32'h80000020);
        serve(6, 0, 32'h11111111, 2'b10, "rr1");
        cyc();
        chk("rr2_saddr", s_addr, 32'h00000010);
        serve(0, 0, 32'h22222222, 2'b01, "rr2");
        cyc();
        chk("rr3_saddr", s_addr, 32'h80000020);
        serve(6, 0, 32'h33333333, 2'b10, "rr3");
        m_valid = 2'b00;

        // m1 sram read, stray s_ready on rom ignored, 3 cycles of s_valid.
        cyc();
        m_valid   = 2'b10;
        m_addr[1] = 32'h80000010;
        m_wstrb   = '0;
        cyc();
        s_ready[0] = 1'b1;
        #1;
        chk("sram_stray_mr", 32'(m_ready), 32'd0);
        chk("sram_stray_sv", 32'(s_valid), 32'h40);
        cyc();
        s_ready[0] = 1'b0;
        chk("sram_stray_state", 32'(dbg_state), 32'd1);
        serve(6, 1, 32'hDEADBEEF, 2'b10, "sram");
        m_valid = 2'b00;

        // m1 write to uart_tx, then uart_rx.
        m_valid    = 2'b10;
        m_addr[1]  = 32'h01000000;
        m_wdata[1] = 32'h00000041;
        m_wstrb[1] = 4'h1;
        cyc();
        chk("utx_sv", 32'(s_valid), 32'h04);
        chk("utx_wstrb", 32'(s_wstrb), 32'h1);
        chk("utx_wdata", s_wdata, 32'h41);
        serve(2, 0, 32'h0, 2'b10, "utx");
        m_addr[1]  = 32'h01000004;
        m_wstrb[1] = 4'h0;
        cyc();
        chk("urx_saddr", s_addr, 32'h01000004);
        serve(3, 1, 32'h000000A5, 2'b10, "urx");
        m_valid = 2'b00;

        // m0 unmapped read -> error pulse, no s_valid.
        m_valid   = 2'b01;
        m_addr[0] = 32'h40000000;
        cyc();
        m_valid = 2'b00;
        chk("unmap_state", 32'(dbg_state), 32'd2);
        chk("unmap_sv", 32'(s_valid), 32'd0);
        chk("unmap_mr", 32'(m_ready), 32'h1);
        chk("unmap_err", 32'(m_error), 32'd1);
        chk("unmap_rdata", m_rdata, 32'd0);
        cyc();
        chk("unmap_after_mr", 32'(m_ready), 32'd0);

        // m0 to spi which never answers: s_valid[1] for 8 cycles, then error.
        // m_valid drops early; completion must still be signalled.
        m_valid   = 2'b01;
        m_addr[0] = 32'h00100008;
        cyc();
        m_valid = 2'b00;
        for (int k = 0; k < 8; k++) begin
            chk("to_sv", 32'(s_valid), 32'h02);
            chk("to_mr", 32'(m_ready), 32'd0);
            cyc();
        end
        chk("to_end_sv", 32'(s_valid), 32'd0);
        chk("to_end_mr", 32'(m_ready), 32'h1);
        chk("to_end_err", 32'(m_error), 32'd1);
        cyc();
        chk("to_idle_state", 32'(dbg_state), 32'd0);

        // Reset while BUSY on clint: immediate clear, late s_ready ignored.
        m_valid   = 2'b10;
        m_addr[1] = 32'h02000010;
        cyc();
        chk("mid_sv", 32'(s_valid), 32'h10);
        reset = 1'b1;
        #1;
        chk("mid_rst_sv", 32'(s_valid), 32'd0);
        chk("mid_rst_state", 32'(dbg_state), 32'd0);
        s_ready[4] = 1'b1;
        #1;
        chk("mid_rst_mr", 32'(m_ready), 32'd0);
        cyc();
        reset   = 1'b0;
        s_ready = 7'd0;
        m_valid = 2'b00;
        cyc();

        // Round robin restarts with m1 after reset.
        m_valid   = 2'b11;
        m_addr[0] = 32'h00000020;
        m_addr[1] = 32'h80000040;
        cyc();
        chk("rr4_saddr", s_addr, 32'h80000040);
        serve(6, 0, 32'h44444444, 2'b10, "rr4");
        cyc();
        chk("rr5_saddr", s_addr, 32'h00000020);
        serve(0, 0, 32'h55555555, 2'b01, "rr5");
        m_valid = 2'b00;
        cyc();
        chk("final_state", 32'(dbg_state), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
